// File: rtl/dino_pkg.sv
// Shared definitions for the dino game blocks: game-state encodings, display constants
// and the scan phase type.
package dino_pkg;

  localparam logic [1:0] ST_DEAD  = 2'd0;
  localparam logic [1:0] ST_GRACE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;

  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam int unsigned BCD_DIGITS = 4;

  typedef enum logic {
    PhBlank,
    PhDrive
  } phase_e;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder (seg[0]=a .. seg[6]=g).
// Non-decimal codes 10-15 decode to all segments off.
module bcd_to_seg7
  import dino_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    unique case (i_bcd)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display_scan.sv
// Time-multiplexed 4-digit score display with inter-digit blanking and dead-state blink.
// Define SCORE_DISPLAY_LZB_EN to enable leading-zero blanking.
module score_display_scan #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter int unsigned BLINK_DIV    = 12500000,
  parameter logic [1:0]  ST_DEAD      = dino_pkg::ST_DEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] i_nums,
  input  logic [1:0]  i_state,
  output logic [3:0]  o_an,
  output logic [6:0]  o_seg,
  output logic        o_dp
);

  localparam int unsigned PhaseMax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned BlinkW   = $clog2(BLINK_DIV + 1);
  localparam int unsigned SnapW    = dino_pkg::BCD_DIGITS * 4;

  dino_pkg::phase_e  phase_q, phase_d;
  logic [PhaseW-1:0] cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic              first_q, first_d;
  logic [SnapW-1:0]  snap_q, snap_d;
  logic              blink_on_q, blink_on_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;

  logic [3:0] nibble;
  logic [6:0] seg_dec;
  logic       lzb_blank;

  // Phase FSM; the first BLANK after reset selects digit 0 instead of advancing.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q + PhaseW'(1);
    idx_d   = idx_q;
    first_d = first_q;
    snap_d  = snap_q;
    unique case (phase_q)
      dino_pkg::PhDrive: begin
        if (cnt_q == PhaseW'(REFRESH_DIV - 1)) begin
          phase_d = dino_pkg::PhBlank;
          cnt_d   = '0;
        end
      end
      dino_pkg::PhBlank: begin
        if (cnt_q == PhaseW'(BLANK_CYCLES - 1)) begin
          phase_d = dino_pkg::PhDrive;
          cnt_d   = '0;
          first_d = 1'b0;
          idx_d   = first_q ? 2'd0 : idx_q + 2'd1;
          // Latch once per frame so a frame never mixes two scores.
          if (idx_d == 2'd0) begin
            snap_d = i_nums;
          end
        end
      end
      default: begin
        phase_d = dino_pkg::PhBlank;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (i_state != ST_DEAD) begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_on_d  = ~blink_on_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BlinkW'(1);
    end
  end

  assign nibble = snap_q[{idx_q, 2'b00} +: 4];

  bcd_to_seg7 u_dec (
    .i_bcd (nibble),
    .o_seg (seg_dec)
  );

`ifdef SCORE_DISPLAY_LZB_EN
  // A digit is a leading zero when it and everything above it is zero; digit 0 always shows.
  assign lzb_blank = (idx_q != 2'd0) && ((snap_q >> {idx_q, 2'b00}) == '0);
`else
  assign lzb_blank = 1'b0;
`endif

  always_comb begin
    an_d  = 4'b1111;
    seg_d = dino_pkg::SEG_BLANK;
    if (phase_q == dino_pkg::PhDrive && blink_on_q && !lzb_blank) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= dino_pkg::PhBlank;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      first_q     <= 1'b1;
      snap_q      <= '0;
      blink_on_q  <= 1'b1;
      blink_cnt_q <= '0;
      an_q        <= 4'b1111;
      seg_q       <= dino_pkg::SEG_BLANK;
    end else begin
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      snap_q      <= snap_d;
      blink_on_q  <= blink_on_d;
      blink_cnt_q <= blink_cnt_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign o_an  = an_q;
  assign o_seg = seg_q;
  assign o_dp  = 1'b1;

endmodule

// File: tb/tb_score_display_scan.sv
// Self-checking bench for score_display_scan: timeline model checked every cycle plus
// directed literal checks. Honours SCORE_DISPLAY_LZB_EN.
module tb_score_display_scan;

  localparam int R  = 4;
  localparam int B  = 1;
  localparam int BD = 20;
  localparam int P  = R + B;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] i_nums = 16'h1234;
  logic [1:0]  i_state = 2'd2;
  logic [3:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;

  int total = 0;
  int bad   = 0;

  score_display_scan #(
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B),
    .BLINK_DIV    (BD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_nums  (i_nums),
    .i_state (i_state),
    .o_an    (o_an),
    .o_seg   (o_seg),
    .o_dp    (o_dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] dec(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Timeline model: n = clock edges since the last reset edge, dead_run = consecutive
  // dead samples, msnap = score captured at each frame start.
  int          n = 0;
  int          dead_run = 0;
  logic [15:0] msnap = '0;
  bit          mvalid = 1'b0;
  logic [3:0]  exp_an = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;

  always @(posedge clk) begin
    int  idx;
    bit  vis;
    if (rst) begin
      exp_an   = 4'hF;
      exp_seg  = 7'h7F;
      n        = 0;
      dead_run = 0;
      msnap    = '0;
      mvalid   = 1'b1;
    end else if (mvalid) begin
      exp_an  = 4'hF;
      exp_seg = 7'h7F;
      if (n >= B && ((n - B) % P) < R && ((dead_run / BD) % 2) == 0) begin
        idx = ((n - B) / P) % 4;
        vis = 1'b1;
`ifdef SCORE_DISPLAY_LZB_EN
        if (idx != 0 && (msnap >> (idx * 4)) == 16'h0) vis = 1'b0;
`endif
        if (vis) begin
          exp_an  = ~(4'b0001 << idx);
          exp_seg = dec(msnap[idx*4 +: 4]);
        end
      end
      n++;
      if (i_state == 2'd0) dead_run++;
      else dead_run = 0;
      if (n >= B && ((n - B) % (4 * P)) == 0) msnap = i_nums;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_an", {28'h0, o_an}, {28'h0, exp_an});
      chk("model_seg", {25'h0, o_seg}, {25'h0, exp_seg});
      chk("model_dp", {31'h0, o_dp}, 32'h1);
    end
  end

  // Skip the rest of the current lit slot, then capture the next lit slot and its length.
  task automatic next_slot(output logic [3:0] an, output logic [6:0] seg, output int len);
    int w;
    an  = 4'hF;
    seg = 7'h7F;
    len = 0;
    w   = 0;
    while (o_an != 4'hF && w < 100) begin @(negedge clk); w++; end
    while (o_an == 4'hF && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) begin
      total++;
      bad++;
      $display("FAIL slot_timeout: got no lit digit within %0d cycles", w);
      return;
    end
    an  = o_an;
    seg = o_seg;
    while (o_an == an && len < 100) begin len++; @(negedge clk); end
  endtask

  task automatic wait_an(input logic [3:0] target);
    int w;
    w = 0;
    while (o_an != target && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_an_timeout: got o_an %b expected %b", o_an, target);
    end
  endtask

  localparam logic [3:0] AN_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  localparam logic [6:0] S1234 [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
  localparam logic [6:0] S5678 [4] = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};

  initial begin
    logic [3:0] an;
    logic [6:0] seg;
    int         len;
    int         cnt;
    logic [3:0] mask;

    repeat (2) @(negedge clk);
    chk("reset_an", {28'h0, o_an}, 32'hF);
    chk("reset_seg", {25'h0, o_seg}, 32'h7F);
    chk("reset_dp", {31'h0, o_dp}, 32'h1);
    rst = 1'b0;

    // Frame of 1234: ones first, 4-cycle slots.
    for (int i = 0; i < 4; i++) begin
      next_slot(an, seg, len);
      chk("s1_an", {28'h0, an}, {28'h0, AN_SEQ[i]});
      chk("s1_seg", {25'h0, seg}, {25'h0, S1234[i]});
      chk("s1_len", len, R);
    end

    // Score change mid-frame must not affect the rest of that frame.
    next_slot(an, seg, len);
    next_slot(an, seg, len);
    wait_an(4'b1011);
    i_nums = 16'h5678;
    next_slot(an, seg, len);
    chk("s2_old_an", {28'h0, an}, 32'h7);
    chk("s2_old_seg", {25'h0, seg}, 32'h79);
    for (int i = 0; i < 4; i++) begin
      next_slot(an, seg, len);
      chk("s2_an", {28'h0, an}, {28'h0, AN_SEQ[i]});
      chk("s2_seg", {25'h0, seg}, {25'h0, S5678[i]});
    end

    // Dead state: 20 visible cycles, then 20 dark ones.
    i_state = 2'd0;
    i_nums  = 16'h0042;
    repeat (BD) @(negedge clk);
    cnt = 0;
    repeat (BD) begin
      @(negedge clk);
      if (o_an != 4'hF || o_seg != 7'h7F) cnt++;
    end
    chk("blink_off_lit_cycles", cnt, 0);
    cnt = 0;
    repeat (BD) begin
      @(negedge clk);
      if (o_an != 4'hF) cnt++;
    end
    chk("blink_on_seen", {31'h0, cnt > 0}, 32'h1);
    repeat (7) @(negedge clk);
    i_state = 2'd2;
    repeat (10) @(negedge clk);

    // Reset mid-DRIVE of digit 2.
    i_nums = 16'h3219;
    repeat (25) @(negedge clk);
    wait_an(4'b1011);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_an", {28'h0, o_an}, 32'hF);
    chk("midrst_seg", {25'h0, o_seg}, 32'h7F);
    rst = 1'b0;
    next_slot(an, seg, len);
    chk("postrst_an", {28'h0, an}, 32'hE);
    chk("postrst_seg", {25'h0, seg}, 32'h10);

`ifndef SCORE_DISPLAY_LZB_EN
    // Non-decimal digits light the anode with no segments.
    i_nums = 16'h00AF;
    repeat (25) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      next_slot(an, seg, len);
      if (an == 4'b1110 || an == 4'b1101) chk("s4_hex_seg", {25'h0, seg}, 32'h7F);
      else chk("s4_zero_seg", {25'h0, seg}, 32'h40);
    end
`else
    i_nums = 16'h0105;
    repeat (25) @(negedge clk);
    mask = 4'h0;
    repeat (60) begin @(negedge clk); mask = mask | ~o_an; end
    chk("lzb_0105_mask", {28'h0, mask}, 32'h7);
    i_nums = 16'h0000;
    repeat (25) @(negedge clk);
    mask = 4'h0;
    cnt  = 0;
    repeat (60) begin
      @(negedge clk);
      mask = mask | ~o_an;
      if (o_an != 4'hF && o_seg != 7'b1000000) cnt++;
    end
    chk("lzb_0000_mask", {28'h0, mask}, 32'h1);
    chk("lzb_0000_seg_errs", cnt, 0);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
